// File: rtl/buck_pwm_latch_blank.sv
// buck_pwm_latch_blank: fixed-frequency PWM latch with leading-edge blanking, deglitched trip, OCP, min-on, max-duty and pulse skip
//   clk        loop clock
//   rstn       asynchronous active-low reset
//   CELV/CELG/SUB  supply, ground and substrate pins (no logic function)
//   en         regulator enable, synchronous to clk
//   comp_trip  asynchronous PWM comparator output (2-flop synchronized, deglitched)
//   ocp_trip   asynchronous overcurrent comparator output (2-flop synchronized)
//   pwm        registered pulse to the loop inverter
//   cyc_start  one-clock pulse at each period start
//   maxduty    one-clock pulse when the pulse is ended by the on-time limit
//   skip       one-clock pulse when a period is skipped
//   ocp_flag   set on an OCP termination, cleared at the next cyc_start
module buck_pwm_latch_blank #(
    parameter int PERIOD   = 100,
    parameter int BLANK    = 6,
    parameter int MIN_ON   = 8,
    parameter int MAX_ON   = 90,
    parameter int DEGLITCH = 2,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic CELV,
    input  logic CELG,
    input  logic SUB,
    input  logic en,
    input  logic comp_trip,
    input  logic ocp_trip,
    output logic pwm,
    output logic cyc_start,
    output logic maxduty,
    output logic skip,
    output logic ocp_flag
);
    localparam int DG_W = (DEGLITCH < 2) ? 1 : $clog2(DEGLITCH + 1);
    localparam logic [CNT_W-1:0] L_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] L_BLANK = CNT_W'(BLANK);
    localparam logic [CNT_W-1:0] L_MIN   = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] L_MAX   = CNT_W'(MAX_ON);
    localparam logic [CNT_W-1:0] L_SAT   = '1;
    localparam logic [DG_W-1:0]  L_DG    = DG_W'(DEGLITCH);

    if (MIN_ON < BLANK || MAX_ON > PERIOD - 4 || PERIOD - 1 >= 2 ** CNT_W) begin : g_bad_params
        $error("buck_pwm_latch_blank: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON, S_OFF} state_t;

    state_t           r_state, w_next;
    logic             r_comp_s1, r_comp_s2, r_ocp_s1, r_ocp_s2, r_ocp_v;
    logic [DG_W-1:0]  r_dg_cnt;
    logic [CNT_W-1:0] r_cnt, r_on_cnt;
    logic             r_pwm, r_cyc_start, r_maxduty, r_skip, r_ocp_flag;
    logic             w_trip_v, w_start, w_next_on, w_skip, w_max, w_ocp_end;
    logic             w_unused;

    assign w_unused  = &{1'b0, CELV, CELG, SUB};
    assign w_trip_v  = r_dg_cnt >= L_DG;
    assign w_start   = en && (r_cnt == '0);
    assign w_next_on = (w_next == S_BLANK) || (w_next == S_ON);

    // Synchronizers and trip filters run regardless of state; blanking only masks their effect
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_comp_s1 <= 1'b0;
            r_comp_s2 <= 1'b0;
            r_ocp_s1  <= 1'b0;
            r_ocp_s2  <= 1'b0;
            r_ocp_v   <= 1'b0;
            r_dg_cnt  <= '0;
        end else begin
            r_comp_s1 <= comp_trip;
            r_comp_s2 <= r_comp_s1;
            r_ocp_s1  <= ocp_trip;
            r_ocp_s2  <= r_ocp_s1;
            r_ocp_v   <= r_ocp_s2;
            r_dg_cnt  <= !r_comp_s2 ? '0 : (w_trip_v ? r_dg_cnt : r_dg_cnt + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= (!en || r_cnt >= L_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    // OCP outranks the comparator trip, which outranks the on-time limit
    always_comb begin
        w_next    = r_state;
        w_skip    = 1'b0;
        w_max     = 1'b0;
        w_ocp_end = 1'b0;
        if (!en) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        w_next = w_trip_v ? S_OFF : S_BLANK;
                        w_skip = w_trip_v;
                    end
                end
                S_BLANK: begin
                    if (r_on_cnt >= L_BLANK) w_next = S_ON;
                end
                S_ON: begin
                    if (r_ocp_v) begin
                        w_next    = S_OFF;
                        w_ocp_end = 1'b1;
                    end else if (w_trip_v && r_on_cnt >= L_MIN) begin
                        w_next = S_OFF;
                    end else if (r_on_cnt >= L_MAX) begin
                        w_next = S_OFF;
                        w_max  = 1'b1;
                    end
                end
                S_OFF: begin
                    if (r_cnt == L_LAST) w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // on_cnt is 1 on the first high clock so that it equals the edge index since the rise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_pwm       <= 1'b0;
            r_cyc_start <= 1'b0;
            r_maxduty   <= 1'b0;
            r_skip      <= 1'b0;
            r_ocp_flag  <= 1'b0;
            r_on_cnt    <= '0;
        end else begin
            r_state     <= w_next;
            r_pwm       <= w_next_on;
            r_cyc_start <= w_start;
            r_maxduty   <= w_max;
            r_skip      <= w_skip;
            r_ocp_flag  <= w_ocp_end | (r_ocp_flag & ~w_start);
            r_on_cnt    <= !w_next_on ? '0 : (!r_pwm ? CNT_W'(1) : (r_on_cnt == L_SAT ? L_SAT : r_on_cnt + 1'b1));
        end
    end

    assign pwm       = r_pwm;
    assign cyc_start = r_cyc_start;
    assign maxduty   = r_maxduty;
    assign skip      = r_skip;
    assign ocp_flag  = r_ocp_flag;
endmodule

// File: tb/tb_buck_pwm_latch_blank.sv
// tb_buck_pwm_latch_blank: directed bench with an edge-indexed behavioural model of the PWM latch
module tb_buck_pwm_latch_blank;
    localparam int PERIOD   = 100;
    localparam int BLANK    = 6;
    localparam int MIN_ON   = 8;
    localparam int MAX_ON   = 90;
    localparam int DEGLITCH = 2;

    logic clk = 1'b0, rstn = 1'b1, en = 1'b0, comp_trip = 1'b0, ocp_trip = 1'b0;
    logic pwm, cyc_start, maxduty, skip, ocp_flag;
    int   checks = 0, failures = 0;

    always #5 clk = ~clk;

    buck_pwm_latch_blank #(
        .PERIOD(PERIOD), .BLANK(BLANK), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .DEGLITCH(DEGLITCH), .CNT_W(8)
    ) dut (
        .clk(clk), .rstn(rstn), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .en(en), .comp_trip(comp_trip), .ocp_trip(ocp_trip),
        .pwm(pwm), .cyc_start(cyc_start), .maxduty(maxduty), .skip(skip), .ocp_flag(ocp_flag)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: inputs sampled per clock edge into arrays; a trip is valid at edge k when the
    // DEGLITCH samples ending 3 edges earlier are all high, an OCP when the sample 3 edges earlier is high.
    bit   hc [0:16383];
    bit   ho [0:16383];
    int   e = 0, rst_mark = 0, ph = 0, age = 0;
    bit   pulse = 0, wait_end = 0;
    logic ex_pwm = 0, ex_cyc = 0, ex_max = 0, ex_skip = 0, ex_flag = 0;

    function automatic bit trip_valid(input int k);
        if (k - 2 - DEGLITCH <= rst_mark) return 1'b0;
        for (int j = k - 2 - DEGLITCH; j <= k - 3; j++) if (!hc[j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit ocp_valid(input int k);
        return (k - 3 > rst_mark) && ho[k - 3];
    endfunction

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            rst_mark = e; ph = 0; age = 0; pulse = 0; wait_end = 0;
            ex_pwm = 0; ex_cyc = 0; ex_max = 0; ex_skip = 0; ex_flag = 0;
        end else begin
            e++;
            hc[e] = comp_trip;
            ho[e] = ocp_trip;
            ex_cyc = 0; ex_max = 0; ex_skip = 0;
            if (!en) begin
                ph = 0; pulse = 0; wait_end = 0;
            end else begin
                if (ph == 0) begin ex_cyc = 1; ex_flag = 0; end
                if (pulse) begin
                    age++;
                    if (age > BLANK) begin
                        if (ocp_valid(e)) begin pulse = 0; wait_end = 1; ex_flag = 1; end
                        else if (trip_valid(e) && age >= MIN_ON) begin pulse = 0; wait_end = 1; end
                        else if (age >= MAX_ON) begin pulse = 0; wait_end = 1; ex_max = 1; end
                    end
                end else if (wait_end) begin
                    if (ph == PERIOD - 1) wait_end = 0;
                end else if (ph == 0) begin
                    if (trip_valid(e)) begin wait_end = 1; ex_skip = 1; end
                    else begin pulse = 1; age = 0; end
                end
                ph = (ph == PERIOD - 1) ? 0 : ph + 1;
            end
            ex_pwm = pulse;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("pwm", int'(pwm), int'(ex_pwm));
        chk("cyc_start", int'(cyc_start), int'(ex_cyc));
        chk("maxduty", int'(maxduty), int'(ex_max));
        chk("skip", int'(skip), int'(ex_skip));
        chk("ocp_flag", int'(ocp_flag), int'(ex_flag));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at t=%0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic high_len(output int w);
        w = 0;
        while (pwm && w < 400) begin w++; @(negedge clk); end
    endtask

    task automatic wait_rise(output int g);
        g = 0;
        while (!pwm && g < 400) begin g++; @(negedge clk); end
    endtask

    initial begin
        int w, g, n_pwm, n_skip, n_cyc;
        en = 1'b1;
        #1 rstn = 1'b0;
        tick(5);
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_cyc", int'(cyc_start), 0);
        chk("rst_maxduty", int'(maxduty), 0);
        chk("rst_skip", int'(skip), 0);
        chk("rst_ocp_flag", int'(ocp_flag), 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("start_cyc", int'(cyc_start), 1);
        chk("start_pwm", int'(pwm), 1);
        high_len(w);
        chk("maxon_width", w, 90);
        chk("maxon_maxduty", int'(maxduty), 1);
        wait_rise(g);
        chk("maxon_period", w + g, 100);

        tick(29);
        comp_trip = 1'b1;
        high_len(w);
        chk("trip_fall", 29 + w, 34);
        chk("trip_no_maxduty", int'(maxduty), 0);
        comp_trip = 1'b0;
        wait_rise(g);
        chk("trip_period", 29 + w + g, 100);

        comp_trip = 1'b1;
        tick(3);
        comp_trip = 1'b0;
        high_len(w);
        chk("blankA_fall", 3 + w, 90);
        chk("blankA_maxduty", int'(maxduty), 1);
        wait_rise(g);

        comp_trip = 1'b1;
        high_len(w);
        comp_trip = 1'b0;
        chk("blankB_fall", w, 8);
        chk("blankB_no_maxduty", int'(maxduty), 0);
        wait_rise(g);
        chk("blankB_period", w + g, 100);

        high_len(w);
        chk("skip_prev_width", w, 90);
        comp_trip = 1'b1;
        tick(10);
        n_pwm = 0; n_skip = 0; n_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            n_pwm  += int'(pwm);
            n_skip += int'(skip);
            n_cyc  += int'(cyc_start);
            if (i == 90) comp_trip = 1'b0;
            @(negedge clk);
        end
        chk("skip_pwm_high_clocks", n_pwm, 0);
        chk("skip_pulses", n_skip, 1);
        chk("skip_cyc_pulses", n_cyc, 1);
        chk("skip_resume", int'(pwm), 1);

        tick(86);
        ocp_trip = 1'b1;
        high_len(w);
        chk("ocp_fall", 86 + w, 90);
        chk("ocp_flag_set", int'(ocp_flag), 1);
        chk("ocp_no_maxduty", int'(maxduty), 0);
        ocp_trip = 1'b0;
        wait_rise(g);
        chk("ocp_period", 86 + w + g, 100);
        chk("ocp_flag_clr", int'(ocp_flag), 0);

        tick(19);
        en = 1'b0;
        @(negedge clk);
        chk("en_drop_pwm", int'(pwm), 0);
        tick(9);
        chk("en_low_cyc", int'(cyc_start), 0);
        en = 1'b1;
        @(negedge clk);
        chk("en_restart_cyc", int'(cyc_start), 1);
        chk("en_restart_pwm", int'(pwm), 1);

        tick(19);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1 chk("rst_async_pwm", int'(pwm), 0);
        tick(3);
        chk("rst_hold_cyc", int'(cyc_start), 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_restart_cyc", int'(cyc_start), 1);
        chk("rst_restart_pwm", int'(pwm), 1);
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
